// File: rtl/phy_rx.sv
// Serial receive side of the 4-lane PHY link: bit-hunts IDLE symbols, locks byte alignment, then
// rebuilds 4-byte frames onto lanes 0..3. Outputs update on the lane-3 LSB edge; no backpressure.
module phy_rx #(
    parameter int         BW         = 8,
    parameter logic [7:0] IDLE_BYTE  = 8'h7C,
    parameter logic [7:0] INV_BYTE   = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic          clk_32f,
    input  logic          rst,
    input  logic          entrada_rx,
    output logic [BW-1:0] out0,
    output logic [BW-1:0] out1,
    output logic [BW-1:0] out2,
    output logic [BW-1:0] out3,
    output logic          valid_out0,
    output logic          valid_out1,
    output logic          valid_out2,
    output logic          valid_out3,
    output logic          IDLE_out,
    output logic          active_out
);

    localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
    localparam int ICW = $clog2(SYNC_COUNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [BW-2:0]  sr, sr_n;
    logic [BW-1:0]  nb;
    logic [BCW-1:0] bit_cnt, bit_cnt_n;
    logic [ICW-1:0] idle_cnt, idle_cnt_n;
    logic [1:0]     lane, lane_n;
    logic [BW-1:0]  buf0, buf1, buf2, buf0_n, buf1_n, buf2_n;
    logic           vbuf0, vbuf1, vbuf2, vbuf0_n, vbuf1_n, vbuf2_n;
    logic [BW-1:0]  out0_n, out1_n, out2_n, out3_n;
    logic           valid0_n, valid1_n, valid2_n, valid3_n;
    logic           idle_out_n, active_n;
    logic           byte_edge;
    logic           is_idle;
    logic [BCW-1:0] bit_cnt_inc;

    assign nb          = {sr, entrada_rx};
    assign sr_n        = nb[BW-2:0];
    assign byte_edge   = (bit_cnt == BCW'(BW - 1));
    assign is_idle     = (nb == BW'(IDLE_BYTE));
    assign bit_cnt_inc = byte_edge ? '0 : bit_cnt + BCW'(1);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        idle_cnt_n = idle_cnt;
        lane_n     = lane;
        buf0_n     = buf0;
        buf1_n     = buf1;
        buf2_n     = buf2;
        vbuf0_n    = vbuf0;
        vbuf1_n    = vbuf1;
        vbuf2_n    = vbuf2;
        out0_n     = out0;
        out1_n     = out1;
        out2_n     = out2;
        out3_n     = out3;
        valid0_n   = valid_out0;
        valid1_n   = valid_out1;
        valid2_n   = valid_out2;
        valid3_n   = valid_out3;
        idle_out_n = IDLE_out;
        active_n   = active_out;

        case (state)
            SEARCH: begin
                if (is_idle) begin
                    state_n    = ALIGN;
                    bit_cnt_n  = '0;
                    idle_cnt_n = ICW'(1);
                end
            end

            ALIGN: begin
                bit_cnt_n = bit_cnt_inc;
                if (byte_edge) begin
                    if (is_idle) begin
                        idle_cnt_n = idle_cnt + ICW'(1);
                        if (idle_cnt + ICW'(1) == ICW'(SYNC_COUNT)) begin
                            state_n    = ACTIVE;
                            active_n   = 1'b1;
                            idle_out_n = 1'b1;
                            lane_n     = 2'd0;
                        end
                    end else begin
                        // alignment guess was wrong: resume the bit-level hunt
                        state_n    = SEARCH;
                        idle_cnt_n = '0;
                        bit_cnt_n  = '0;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_n = bit_cnt_inc;
                if (byte_edge) begin
                    if (is_idle) begin
                        // an IDLE drops any partial frame and re-anchors the next byte on lane 0
                        idle_out_n = 1'b1;
                        lane_n     = 2'd0;
                        valid0_n   = 1'b0;
                        valid1_n   = 1'b0;
                        valid2_n   = 1'b0;
                        valid3_n   = 1'b0;
                    end else begin
                        idle_out_n = 1'b0;
                        lane_n     = lane + 2'd1;
                        case (lane)
                            2'd0: begin
                                buf0_n  = nb;
                                vbuf0_n = (nb != BW'(INV_BYTE));
                            end
                            2'd1: begin
                                buf1_n  = nb;
                                vbuf1_n = (nb != BW'(INV_BYTE));
                            end
                            2'd2: begin
                                buf2_n  = nb;
                                vbuf2_n = (nb != BW'(INV_BYTE));
                            end
                            default: begin
                                out0_n   = buf0;
                                out1_n   = buf1;
                                out2_n   = buf2;
                                out3_n   = nb;
                                valid0_n = vbuf0;
                                valid1_n = vbuf1;
                                valid2_n = vbuf2;
                                valid3_n = (nb != BW'(INV_BYTE));
                            end
                        endcase
                    end
                end
            end

            default: begin
                state_n = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (rst) begin
            state      <= SEARCH;
            sr         <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            lane       <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            buf2       <= '0;
            vbuf0      <= 1'b0;
            vbuf1      <= 1'b0;
            vbuf2      <= 1'b0;
            out0       <= '0;
            out1       <= '0;
            out2       <= '0;
            out3       <= '0;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            valid_out2 <= 1'b0;
            valid_out3 <= 1'b0;
            IDLE_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            bit_cnt    <= bit_cnt_n;
            idle_cnt   <= idle_cnt_n;
            lane       <= lane_n;
            buf0       <= buf0_n;
            buf1       <= buf1_n;
            buf2       <= buf2_n;
            vbuf0      <= vbuf0_n;
            vbuf1      <= vbuf1_n;
            vbuf2      <= vbuf2_n;
            out0       <= out0_n;
            out1       <= out1_n;
            out2       <= out2_n;
            out3       <= out3_n;
            valid_out0 <= valid0_n;
            valid_out1 <= valid1_n;
            valid_out2 <= valid2_n;
            valid_out3 <= valid3_n;
            IDLE_out   <= idle_out_n;
            active_out <= active_n;
        end
    end

endmodule

// File: tb/tb_phy_rx.sv
// Directed-vector bench for phy_rx: serial bytes in, lane outputs checked 1ns after each LSB edge.
module tb_phy_rx;

    logic       clk_32f = 1'b0;
    logic       rst;
    logic       entrada_rx;
    logic [7:0] out0, out1, out2, out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       IDLE_out, active_out;

    int vectors     = 0;
    int miscompares = 0;

    phy_rx dut (
        .clk_32f    (clk_32f),
        .rst        (rst),
        .entrada_rx (entrada_rx),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .IDLE_out   (IDLE_out),
        .active_out (active_out)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive one bit, let the rising edge take it, return 1ns after the edge
    task automatic send_bit(input logic b);
        entrada_rx = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send_bit(1'b0);
        send_bit(1'b0);
        rst = 1'b0;
    endtask

    task automatic sync_link();
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h7C);
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] outs, input logic [3:0] vlds);
        chk({tag, "_out0"}, {24'h0, out0}, {24'h0, outs[31:24]});
        chk({tag, "_out1"}, {24'h0, out1}, {24'h0, outs[23:16]});
        chk({tag, "_out2"}, {24'h0, out2}, {24'h0, outs[15:8]});
        chk({tag, "_out3"}, {24'h0, out3}, {24'h0, outs[7:0]});
        chk({tag, "_vld"}, {28'h0, valid_out0, valid_out1, valid_out2, valid_out3}, {28'h0, vlds});
    endtask

    initial begin
        rst        = 1'b1;
        entrada_rx = 1'b0;
        @(posedge clk_32f);
        #1;

        // 1: reset, then a dead line
        do_reset();
        chk_frame("rst", 32'h0, 4'b0000);
        chk("rst_idle", {31'h0, IDLE_out}, 32'h0);
        chk("rst_active", {31'h0, active_out}, 32'h0);
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        chk_frame("zeros", 32'h0, 4'b0000);
        chk("zeros_active", {31'h0, active_out}, 32'h0);

        // 2: four IDLEs behind a 3-bit offset
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h7C);
        chk("off3_active_3rd", {31'h0, active_out}, 32'h0);
        send_byte(8'h7C);
        chk("off3_active_4th", {31'h0, active_out}, 32'h1);
        chk("off3_idle_4th", {31'h0, IDLE_out}, 32'h1);

        // 3: full valid frame, then a held frame, then an IDLE
        sync_link();
        send_byte(8'hA1);
        chk("f3_idle_lane0", {31'h0, IDLE_out}, 32'h0);
        chk("f3_v0_early", {31'h0, valid_out0}, 32'h0);
        send_byte(8'hB2);
        send_byte(8'hC3);
        chk("f3_out0_early", {24'h0, out0}, 32'h0);
        send_byte(8'hD4);
        chk_frame("f3", 32'hA1B2C3D4, 4'b1111);
        chk("f3_idle", {31'h0, IDLE_out}, 32'h0);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        chk_frame("f3_hold", 32'hA1B2C3D4, 4'b1111);
        send_byte(8'h40);
        chk_frame("f3b", 32'h10203040, 4'b1111);
        send_byte(8'h7C);
        chk_frame("f3_idle_clr", 32'h10203040, 4'b0000);
        chk("f3_idle_after", {31'h0, IDLE_out}, 32'h1);

        // 4: INV filler slots
        sync_link();
        send_byte(8'h55);
        send_byte(8'hBC);
        send_byte(8'h77);
        send_byte(8'hBC);
        chk_frame("f4", 32'h55BC77BC, 4'b1010);

        // 5: partial frame aborted by IDLE, next frame restarts at lane 0
        sync_link();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h7C);
        chk_frame("f5_abort", 32'h0, 4'b0000);
        chk("f5_idle", {31'h0, IDLE_out}, 32'h1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk_frame("f5", 32'h01020304, 4'b1111);

        // 6: broken alignment run, late sync, then reset mid-frame
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'h7C);
        send_byte(8'h00);
        chk("f6_after_break", {31'h0, active_out}, 32'h0);
        for (int i = 0; i < 3; i++) send_byte(8'h7C);
        chk("f6_3rd_late", {31'h0, active_out}, 32'h0);
        send_byte(8'h7C);
        chk("f6_4th_late", {31'h0, active_out}, 32'h1);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
        chk_frame("f6_frame", 32'hA1B2C3D4, 4'b1111);
        send_byte(8'hE5);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        send_bit(1'b0);
        rst = 1'b0;
        chk_frame("f6_midrst", 32'h0, 4'b0000);
        chk("f6_midrst_active", {31'h0, active_out}, 32'h0);
        chk("f6_midrst_idle", {31'h0, IDLE_out}, 32'h0);
        for (int i = 0; i < 4; i++) send_byte(8'h7C);
        chk("f6_resync", {31'h0, active_out}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
